// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg: shared size constants for the write-back trace FIFO
//   TRACE_DW    write-back data width (WIDTH+1 of the processing unit)
//   TRACE_DEPTH FIFO entries, power of two
//   TRACE_SW    cycle-stamp width
//   TRACE_DCW   dropped-entry counter width
package wb_trace_pkg;
    localparam int TRACE_DW    = 17;
    localparam int TRACE_DEPTH = 8;
    localparam int TRACE_SW    = 16;
    localparam int TRACE_DCW   = 8;
endpackage

// File: rtl/wb_trace_ram.sv
// wb_trace_ram: DEPTH x W storage, one synchronous write port, one asynchronous read port
//   clk    clock
//   we     write enable, writes wdata to mem[waddr] at the rising edge
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  mem[raddr], combinational
module wb_trace_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 33
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/wb_trace.sv
// wb_trace: stamped FIFO trace of register write-backs, drained over valid/ready, never stalls
//   clk, rst             clock, synchronous active-high reset
//   we, rwd              write-back strobe and data
//   clr                  clears overflow and drop_cnt (FIFO untouched)
//   out_valid/out_ready  first-word-fall-through head handshake
//   out_data, out_stamp  head entry data and cycle stamp
//   count                occupancy 0..DEPTH
//   overflow, drop_cnt   sticky drop flag, saturating drop counter
module wb_trace
    import wb_trace_pkg::*;
#(
    parameter int DW    = TRACE_DW,
    parameter int DEPTH = TRACE_DEPTH,
    parameter int SW    = TRACE_SW,
    parameter int DCW   = TRACE_DCW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [DW-1:0]          rwd,
    input  logic                   clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [SW-1:0]          out_stamp,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DCW-1:0]         drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [SW-1:0]    stamp;
    logic [SW+DW-1:0] head;
    logic             pop, full, push_acc, drop;
    assign out_valid = count != '0;
    assign pop       = out_valid & out_ready;
    assign full      = count == (AW+1)'(DEPTH);
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push_acc  = we & (~full | pop);
    assign drop      = we & full & ~pop;
    assign {out_stamp, out_data} = head;
    wb_trace_ram #(.DEPTH(DEPTH), .W(SW+DW)) u_trace_ram (
        .clk   (clk),
        .we    (push_acc & ~rst),
        .waddr (wr_ptr),
        .wdata ({stamp, rwd}),
        .raddr (rd_ptr),
        .rdata (head)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            stamp    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            stamp    <= stamp + SW'(1);
            wr_ptr   <= push_acc ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count    <= count + (AW+1)'(push_acc) - (AW+1)'(pop);
            // a drop in the clr cycle wins over the clear
            overflow <= drop | (overflow & ~clr);
            drop_cnt <= drop ? (clr ? DCW'(1) : (&drop_cnt ? drop_cnt : drop_cnt + DCW'(1)))
                             : (clr ? '0 : drop_cnt);
        end
    end
endmodule
